// File: rtl/accel_pkg.sv
// Shared types and constants for the matrix-multiply tile sequencer.
package accel_pkg;

    localparam int NUM_SIZE_DEF = 16;

    // Bit positions inside the 2-bit mode word
    localparam int MODE_ACC = 0;
    localparam int MODE_TRB = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        LOAD_C = 3'd3,
        RUN    = 3'd4,
        DRAIN  = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Skewed feed of an N x N tile takes 3N-2 steps, plus the array's settle latency
    function automatic int run_len(input int n, input int lat);
        return 3 * n - 2 + lat;
    endfunction

endpackage

// File: rtl/skew_feeder.sv
// Holds the A and B operand tiles and presents them to the array as
// diagonally skewed west (rows of A) and north (columns of B) vectors.
module skew_feeder #(
    parameter int NUM_SIZE  = 16,
    parameter int GRID_SIZE = 2,
    parameter int IDX_W     = 2,
    parameter int STEP_W    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          a_we,
    input  logic                          b_we,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [NUM_SIZE-1:0]           wr_data,
    input  logic                          feed_en,
    input  logic [STEP_W-1:0]             step,
    output logic [GRID_SIZE*NUM_SIZE-1:0] north_input,
    output logic [GRID_SIZE*NUM_SIZE-1:0] west_input
);

    localparam int NN = GRID_SIZE * GRID_SIZE;

    logic [NUM_SIZE-1:0] a_buf [NN];
    logic [NUM_SIZE-1:0] b_buf [NN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NN; k++) begin
                a_buf[k] <= '0;
                b_buf[k] <= '0;
            end
        end else begin
            if (a_we) a_buf[wr_idx] <= wr_data;
            if (b_we) b_buf[wr_idx] <= wr_data;
        end
    end

    // Lane i carries element index (step - i); outside 0..N-1 the lane idles at zero
    always_comb begin
        int k;
        k           = 0;
        north_input = '0;
        west_input  = '0;
        if (feed_en) begin
            for (int i = 0; i < GRID_SIZE; i++) begin
                k = int'(step) - i;
                if (k >= 0 && k < GRID_SIZE) begin
                    west_input[i*NUM_SIZE +: NUM_SIZE]  = a_buf[IDX_W'(i * GRID_SIZE + k)];
                    north_input[i*NUM_SIZE +: NUM_SIZE] = b_buf[IDX_W'(k * GRID_SIZE + i)];
                end
            end
        end
    end

endmodule

// File: rtl/mxu_tile_sequencer.sv
// Sequences one N x N tile multiply: loads A, B (optionally transposed) and C,
// drives the skewed systolic feed, then writes C = A*B (+C) back row-major.
module mxu_tile_sequencer
    import accel_pkg::*;
#(
    parameter int NUM_SIZE  = NUM_SIZE_DEF,
    parameter int GRID_SIZE = 2,
    parameter int ADDR_W    = 5,
    parameter int MXU_LAT   = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [ADDR_W-1:0]                       a_base,
    input  logic [ADDR_W-1:0]                       b_base,
    input  logic [ADDR_W-1:0]                       c_base,
    input  logic [1:0]                              mode,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    mem_rd_en,
    output logic [ADDR_W-1:0]                       mem_rd_addr,
    input  logic [NUM_SIZE-1:0]                     mem_rd_data,
    output logic                                    mem_wr_en,
    output logic [ADDR_W-1:0]                       mem_wr_addr,
    output logic [NUM_SIZE-1:0]                     mem_wr_data,
    output logic                                    mxu_ce,
    output logic                                    mxu_clear,
    output logic [GRID_SIZE*NUM_SIZE-1:0]           north_input,
    output logic [GRID_SIZE*NUM_SIZE-1:0]           west_input,
    input  logic [GRID_SIZE*GRID_SIZE*NUM_SIZE-1:0] result_out,
    output state_t                                  dbg_state
);

    localparam int NN      = GRID_SIZE * GRID_SIZE;
    localparam int RUN_LEN = run_len(GRID_SIZE, MXU_LAT);
    localparam int CNT_MAX = (NN + 1 > RUN_LEN) ? NN + 1 : RUN_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NN);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   a_base_q, b_base_q, c_base_q;
    logic [1:0]          mode_q;
    logic [NUM_SIZE-1:0] c_buf      [NN];
    logic [NUM_SIZE-1:0] result_arr [NN];

    logic              accept, load_last, run_last, drain_last, loading;
    logic              cap_valid, a_we, b_we, c_we, feed_en, wr_issue;
    logic [IDX_W-1:0]  cap_idx, wr_idx;
    logic [ADDR_W-1:0] rd_base;
    int                cap_t;

    assign accept     = (state == IDLE) && start;
    assign load_last  = (cnt == CNT_W'(NN));
    assign run_last   = (cnt == CNT_W'(RUN_LEN - 1));
    assign drain_last = (cnt == CNT_W'(NN - 1));
    assign dbg_state  = state;

    // cnt is the cycle index within the current state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = LOAD_A;
            LOAD_A:  if (load_last)  state_nxt = LOAD_B;
            LOAD_B:  if (load_last)  state_nxt = mode_q[MODE_ACC] ? LOAD_C : RUN;
            LOAD_C:  if (load_last)  state_nxt = RUN;
            RUN:     if (run_last)   state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        mxu_ce    = (state == RUN);
        feed_en   = (state == RUN);
        loading   = (state inside {LOAD_A, LOAD_B, LOAD_C});
        mem_rd_en = loading && (cnt < CNT_W'(NN));
        case (state)
            LOAD_A:  rd_base = a_base_q;
            LOAD_B:  rd_base = b_base_q;
            LOAD_C:  rd_base = c_base_q;
            default: rd_base = '0;
        endcase
        mem_rd_addr = mem_rd_en ? rd_base + ADDR_W'(cnt) : '0;

        // Read data lags the address by one cycle, so cycle t captures word t-1
        cap_valid = loading && (cnt != '0);
        cap_t     = int'(cnt) - 1;
        a_we      = cap_valid && (state == LOAD_A);
        b_we      = cap_valid && (state == LOAD_B);
        c_we      = cap_valid && (state == LOAD_C);
        cap_idx   = IDX_W'(cap_t);
        if (state == LOAD_B && mode_q[MODE_TRB])
            cap_idx = IDX_W'((cap_t % GRID_SIZE) * GRID_SIZE + cap_t / GRID_SIZE);

        // Write d is registered one cycle early so it is on the bus in DRAIN cycle d
        wr_issue = (state == RUN && run_last) || (state == DRAIN && !drain_last);
        wr_idx   = (state == DRAIN) ? IDX_W'(int'(cnt) + 1) : '0;
    end

    always_comb begin
        for (int k = 0; k < NN; k++)
            result_arr[k] = result_out[k*NUM_SIZE +: NUM_SIZE];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_base_q    <= '0;
            b_base_q    <= '0;
            c_base_q    <= '0;
            mode_q      <= '0;
            mxu_clear   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            for (int k = 0; k < NN; k++) c_buf[k] <= '0;
        end else begin
            mxu_clear <= accept;
            if (accept) begin
                a_base_q <= a_base;
                b_base_q <= b_base;
                c_base_q <= c_base;
                mode_q   <= mode;
            end
            if (c_we) c_buf[cap_idx] <= mem_rd_data;
            mem_wr_en <= wr_issue;
            if (wr_issue) begin
                mem_wr_addr <= c_base_q + ADDR_W'(wr_idx);
                mem_wr_data <= result_arr[wr_idx] + (mode_q[MODE_ACC] ? c_buf[wr_idx] : '0);
            end
        end
    end

    skew_feeder #(
        .NUM_SIZE  (NUM_SIZE),
        .GRID_SIZE (GRID_SIZE),
        .IDX_W     (IDX_W),
        .STEP_W    (CNT_W)
    ) u_skew_feeder (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_we        (a_we),
        .b_we        (b_we),
        .wr_idx      (cap_idx),
        .wr_data     (mem_rd_data),
        .feed_en     (feed_en),
        .step        (cnt),
        .north_input (north_input),
        .west_input  (west_input)
    );

endmodule
